// File: rtl/hwpe_ctrl_regfile_parity_scan_pkg.sv
// Shared types and constants for the HWPE control register-file parity scanner.
package hwpe_ctrl_regfile_parity_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } parity_scan_state_e;

    localparam int unsigned PARITY_SIG_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/hwpe_ctrl_regfile_parity_scan_fold.sv
// Combinational XOR fold of one group of registers down to SIG_WIDTH bits.
// Slots whose valid bit is low (past the end of the file) contribute zero.
module hwpe_ctrl_parity_fold #(
    parameter int unsigned REG_WIDTH      = 32,
    parameter int unsigned SIG_WIDTH      = 16,
    parameter int unsigned REGS_PER_CYCLE = 1
) (
    input  logic [REGS_PER_CYCLE*REG_WIDTH-1:0] group,
    input  logic [REGS_PER_CYCLE-1:0]           valid,
    output logic [SIG_WIDTH-1:0]                sig
);

    localparam int unsigned SLICES = REG_WIDTH / SIG_WIDTH;

    always_comb begin
        sig = '0;
        for (int j = 0; j < int'(REGS_PER_CYCLE); j++) begin
            if (valid[j]) begin
                for (int s = 0; s < int'(SLICES); s++) begin
                    sig = sig ^ group[j*REG_WIDTH + s*SIG_WIDTH +: SIG_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/hwpe_ctrl_regfile_parity_scan.sv
// Multi-cycle even-parity scanner for the HWPE control register file.
// Optional error injection for self-test is enabled by defining HWPE_CTRL_PARITY_ERR_INJ_EN.
module hwpe_ctrl_regfile_parity_scan
    import hwpe_ctrl_regfile_parity_scan_pkg::*;
#(
    parameter int unsigned N_REGS         = 24,
    parameter int unsigned REG_WIDTH      = 32,
    parameter int unsigned SIG_WIDTH      = PARITY_SIG_WIDTH_DEFAULT,
    parameter int unsigned REGS_PER_CYCLE = 1,
    parameter int unsigned CONTINUOUS     = 0,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_REGS*REG_WIDTH-1:0] regs_i,
    input  logic                        start_i,
    input  logic                        clear_i,
`ifdef HWPE_CTRL_PARITY_ERR_INJ_EN
    input  logic                        inject_i,
`endif
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        mismatch_o,
    output logic                        fault_o,
    output logic [CNT_WIDTH-1:0]        fault_cnt_o,
    output logic [SIG_WIDTH-1:0]        signature_o
);

    localparam int unsigned IDX_W = $clog2(N_REGS + REGS_PER_CYCLE + 1);
    localparam int unsigned SEL_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;

    if (REG_WIDTH % SIG_WIDTH != 0) begin : g_width_check
        $error("REG_WIDTH must be a multiple of SIG_WIDTH");
    end
    if (REGS_PER_CYCLE < 1 || REGS_PER_CYCLE > N_REGS) begin : g_rpc_check
        $error("REGS_PER_CYCLE must lie in 1..N_REGS");
    end

    parity_scan_state_e                  state;
    logic [IDX_W-1:0]                    idx;
    logic [SIG_WIDTH-1:0]                acc;
    logic [SIG_WIDTH-1:0]                signature;
    logic                                fault;
    logic [CNT_WIDTH-1:0]                fault_cnt;

    logic [REG_WIDTH-1:0]                reg_arr [N_REGS];
    logic [REGS_PER_CYCLE*REG_WIDTH-1:0] group;
    logic [REGS_PER_CYCLE-1:0]           valid;
    logic [SIG_WIDTH-1:0]                fold_sig;
    logic [SIG_WIDTH-1:0]                inj;
    logic                                last_group;

    for (genvar k = 0; k < int'(N_REGS); k++) begin : g_regs
        assign reg_arr[k] = regs_i[k*REG_WIDTH +: REG_WIDTH];
    end

    // Gather the current group; slots beyond the file end are masked off.
    always_comb begin
        group = '0;
        valid = '0;
        for (int j = 0; j < int'(REGS_PER_CYCLE); j++) begin
            if (int'(idx) + j < int'(N_REGS)) begin
                valid[j] = 1'b1;
                group[j*REG_WIDTH +: REG_WIDTH] = reg_arr[SEL_W'(int'(idx) + j)];
            end
        end
    end

    assign last_group = (int'(idx) + int'(REGS_PER_CYCLE) >= int'(N_REGS));

`ifdef HWPE_CTRL_PARITY_ERR_INJ_EN
    assign inj = SIG_WIDTH'(inject_i);
`else
    assign inj = '0;
`endif

    hwpe_ctrl_parity_fold #(
        .REG_WIDTH      (REG_WIDTH),
        .SIG_WIDTH      (SIG_WIDTH),
        .REGS_PER_CYCLE (REGS_PER_CYCLE)
    ) u_fold (
        .group (group),
        .valid (valid),
        .sig   (fold_sig)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            signature <= '0;
            fault     <= 1'b0;
            fault_cnt <= '0;
        end else begin
            if (clear_i) begin
                fault     <= 1'b0;
                fault_cnt <= '0;
            end
            case (state)
                IDLE: begin
                    if (start_i || CONTINUOUS != 0) begin
                        state <= SCAN;
                        acc   <= '0;
                        idx   <= '0;
                    end
                end
                SCAN: begin
                    acc <= acc ^ fold_sig ^ inj;
                    idx <= idx + IDX_W'(REGS_PER_CYCLE);
                    if (last_group) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    signature <= acc;
                    // A mismatch in this cycle overrides a simultaneous clear.
                    if (|acc) begin
                        fault <= 1'b1;
                        if (clear_i) begin
                            fault_cnt <= CNT_WIDTH'(1);
                        end else if (!(&fault_cnt)) begin
                            fault_cnt <= fault_cnt + CNT_WIDTH'(1);
                        end
                    end
                    if (CONTINUOUS != 0) begin
                        state <= SCAN;
                        acc   <= '0;
                        idx   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o      = (state != IDLE);
    assign done_o      = (state == DONE);
    assign mismatch_o  = (state == DONE) && (|acc);
    assign fault_o     = fault;
    assign fault_cnt_o = fault_cnt;
    assign signature_o = signature;

endmodule
